// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit between the PC generator and the instruction memory
// bus. It takes one fetch address at a time, rejects misaligned addresses
// without touching the bus, and issues a single read over a request/grant/
// response bus. The returned word is held for decode under a valid/ack
// handshake. Redirect flushes, bus errors and bus timeouts are also handled.
//
// Optional feature (compile-time macro IFETCH_REUSE_EN):
//   Adds a one-entry reuse buffer (tag, data, valid). A fetch that hits it
//   completes in one cycle without a bus access. fence_i invalidates it.
//   Without the macro, every aligned fetch uses the bus and fence_i is unused.
//
// Parameters:
//   ADDR_W          fetch address / imem_addr width
//   DATA_W          instruction width
//   TIMEOUT_CYCLES  max cycles waiting for a response before a bus fault
//   NOP_INSTR       instruction presented on any fault
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   pc_in           fetch address from the PC generator
//   pc_valid        fetch request for pc_in
//   flush           redirect; abandon the current fetch
//   fence_i         invalidate the reuse buffer
//   instr_out       fetched instruction (NOP_INSTR on fault)
//   instr_valid     instr_out and the fault flags are valid
//   instr_ack       decode consumed the instruction
//   misalign_fault  pc_in[1:0] != 0, qualified by instr_valid
//   bus_fault       bus error or timeout, qualified by instr_valid
//   fetch_busy      unit is not idle
//   imem_req        bus read request
//   imem_addr       bus read address
//   imem_gnt        request accepted
//   imem_rvalid     response valid
//   imem_rdata      response data
//   imem_err        response error, qualified by imem_rvalid
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0] NOP_INSTR      = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  input  logic              flush,
  input  logic              fence_i,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ack,
  output logic              misalign_fault,
  output logic              bus_fault,
  output logic              fetch_busy,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  // The counter is cleared on entry to WAIT and advances once per cycle, so
  // when it holds TIMEOUT_CYCLES-2 this is the last cycle before it would
  // reach TIMEOUT_CYCLES-1. Acting on that value makes the fault visible
  // exactly TIMEOUT_CYCLES-1 cycles after entering WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              mis_q,   mis_d;
  logic              bus_q,   bus_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              misaligned;
  logic              timeout;
  logic              reuse_hit;
  logic [DATA_W-1:0] reuse_data;

  assign misaligned = (pc_in[1:0] != 2'b00);
  assign timeout    = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Optional reuse buffer
  // ---------------------------------------------------------------------------
`ifdef IFETCH_REUSE_EN
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] buf_q;
  logic              buf_valid_q;
  logic              fill;

  // Fill on every clean WAIT->VALID transition: response arrived without
  // error and no flush pre-empted it (a timeout cannot coincide with rvalid
  // because rvalid is checked first).
  assign fill       = (state_q == S_WAIT) && imem_rvalid && !imem_err && !flush;
  assign reuse_hit  = buf_valid_q && (pc_in == tag_q);
  assign reuse_data = buf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
    end else if (fence_i) begin
      buf_valid_q <= 1'b0;          // fence_i wins over a same-cycle fill
    end else if (fill) begin
      buf_valid_q <= 1'b1;
    end
  end

  // NOTE: tag/data are storage guarded by buf_valid_q, so they take no reset;
  // only the valid bit needs a known value out of reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q <= addr_q;
      buf_q <= imem_rdata;
    end
  end
`else
  logic unused_fence_i;

  assign unused_fence_i = fence_i;
  assign reuse_hit      = 1'b0;
  assign reuse_data     = '0;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
      bus_q   <= bus_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update. Priority everywhere: flush > pc_valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a hold default first, so no path through the
    // case below can leave a variable unassigned and infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    bus_d   = bus_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (!flush && pc_valid) begin
          if (misaligned) begin
            state_d = S_VALID;
            instr_d = NOP_INSTR;
            mis_d   = 1'b1;
            bus_d   = 1'b0;
          end else if (reuse_hit) begin
            state_d = S_VALID;
            instr_d = reuse_data;
            mis_d   = 1'b0;
            bus_d   = 1'b0;
          end else begin
            state_d = S_REQ;
            addr_d  = pc_in;
          end
        end
      end

      S_REQ: begin
        // A grant in the flush cycle still leaves a read in flight, which
        // must be drained before the bus can be reused.
        if (imem_gnt) begin
          cnt_d = '0;
        end
        if (flush) begin
          state_d = imem_gnt ? S_DRAIN : S_IDLE;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) begin
          // A response or timeout arriving with the flush ends the read now;
          // otherwise it is still outstanding and goes to DRAIN.
          state_d = (imem_rvalid || timeout) ? S_IDLE : S_DRAIN;
        end else if (imem_rvalid) begin
          state_d = S_VALID;
          instr_d = imem_err ? NOP_INSTR : imem_rdata;
          bus_d   = imem_err;
          mis_d   = 1'b0;
        end else if (timeout) begin
          state_d = S_VALID;
          instr_d = NOP_INSTR;
          bus_d   = 1'b1;
          mis_d   = 1'b0;
        end
      end

      S_VALID: begin
        if (flush) begin
          state_d = S_IDLE;
          mis_d   = 1'b0;
          bus_d   = 1'b0;
        end else if (instr_ack) begin
          if (!pc_valid) begin
            state_d = S_IDLE;
            mis_d   = 1'b0;
            bus_d   = 1'b0;
          end else if (misaligned) begin
            instr_d = NOP_INSTR;
            mis_d   = 1'b1;
            bus_d   = 1'b0;
          end else if (reuse_hit) begin
            instr_d = reuse_data;
            mis_d   = 1'b0;
            bus_d   = 1'b0;
          end else begin
            state_d = S_REQ;
            addr_d  = pc_in;
            mis_d   = 1'b0;
            bus_d   = 1'b0;
          end
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (imem_rvalid || timeout) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign instr_out      = instr_q;
  assign instr_valid    = (state_q == S_VALID);
  assign misalign_fault = instr_valid && mis_q;
  assign bus_fault      = instr_valid && bus_q;
  assign fetch_busy     = (state_q != S_IDLE);
  assign imem_req       = (state_q == S_REQ);
  assign imem_addr      = addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Cycle-table bench for instr_fetch. Each table row gives the inputs driven
// during one clock cycle and the outputs expected during that same cycle
// (outputs are registered state, sampled on the falling edge). Multi-cycle
// corner cases (timeout, reset mid-read, reuse buffer) are hand-written.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        flush;
  logic        fence_i;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ack;
  logic        misalign_fault;
  logic        bus_fault;
  logic        fetch_busy;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .flush          (flush),
    .fence_i        (fence_i),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .instr_ack      (instr_ack),
    .misalign_fault (misalign_fault),
    .bus_fault      (bus_fault),
    .fetch_busy     (fetch_busy),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        fl;
    logic        ack;
    logic        gnt;
    logic        rv;
    logic        err;
    logic [31:0] rd;
    logic        e_valid;
    logic        e_mis;
    logic        e_bus;
    logic        e_busy;
    logic        e_req;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic pv, input logic [31:0] pc,
                              input logic fl, input logic ack, input logic gnt,
                              input logic rv, input logic err, input logic [31:0] rd,
                              input logic ev, input logic em, input logic eb,
                              input logic ebusy, input logic ereq,
                              input logic [31:0] ei, input logic [31:0] ea);
    vec_t v;
    v.pv = pv; v.pc = pc; v.fl = fl; v.ack = ack; v.gnt = gnt;
    v.rv = rv; v.err = err; v.rd = rd;
    v.e_valid = ev; v.e_mis = em; v.e_bus = eb; v.e_busy = ebusy;
    v.e_req = ereq; v.e_instr = ei; v.e_addr = ea;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic em,
                               input logic eb, input logic ebusy, input logic ereq,
                               input logic [31:0] ei, input logic [31:0] ea);
    check({tag, ".instr_valid"},    {31'd0, instr_valid},    {31'd0, ev});
    check({tag, ".misalign_fault"}, {31'd0, misalign_fault}, {31'd0, em});
    check({tag, ".bus_fault"},      {31'd0, bus_fault},      {31'd0, eb});
    check({tag, ".fetch_busy"},     {31'd0, fetch_busy},     {31'd0, ebusy});
    check({tag, ".imem_req"},       {31'd0, imem_req},       {31'd0, ereq});
    check({tag, ".instr_out"},      instr_out,               ei);
    check({tag, ".imem_addr"},      imem_addr,               ea);
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge where the caller samples the outputs for that cycle.
  task automatic step(input logic rst, input logic pv, input logic [31:0] pc,
                      input logic fl, input logic fen, input logic ack,
                      input logic gnt, input logic rv, input logic err,
                      input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst_n       = rst;
    pc_valid    = pv;
    pc_in       = pc;
    flush       = fl;
    fence_i     = fen;
    instr_ack   = ack;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_err    = err;
    imem_rdata  = rd;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;

    rst_n = 1'b0; pc_valid = 1'b0; pc_in = '0; flush = 1'b0; fence_i = 1'b0;
    instr_ack = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0;
    imem_rdata = '0;

    // Reset state
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_outputs("reset", 0, 0, 0, 0, 0, 32'h0, 32'h0);

    //   pv  pc            fl ack gnt rv err rd               | v m b busy req instr          addr
    // Basic fetch from 0x10
    add(1, 32'h00000010, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, 32'h00000000, 32'h00);
    add(0, 32'h0,        0, 0, 1, 0, 0, 32'h0,            0, 0, 0, 1, 1, 32'h00000000, 32'h10);
    add(0, 32'h0,        0, 0, 0, 1, 0, 32'h00500093,     0, 0, 0, 1, 0, 32'h00000000, 32'h10);
    add(0, 32'h0,        0, 0, 0, 0, 0, 32'h0,            1, 0, 0, 1, 0, 32'h00500093, 32'h10);
    add(0, 32'h0,        0, 1, 0, 0, 0, 32'h0,            1, 0, 0, 1, 0, 32'h00500093, 32'h10);
    add(0, 32'h0,        0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, 32'h00500093, 32'h10);
    // Misaligned 0x06: no bus access
    add(1, 32'h00000006, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, 32'h00500093, 32'h10);
    add(0, 32'h0,        0, 1, 0, 0, 0, 32'h0,            1, 1, 0, 1, 0, NOP,          32'h10);
    // Bus error on 0x18
    add(1, 32'h00000018, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, NOP,          32'h10);
    add(0, 32'h0,        0, 0, 1, 0, 0, 32'h0,            0, 0, 0, 1, 1, NOP,          32'h18);
    add(0, 32'h0,        0, 0, 0, 1, 1, 32'h12345678,     0, 0, 0, 1, 0, NOP,          32'h18);
    add(0, 32'h0,        0, 1, 0, 0, 0, 32'h0,            1, 0, 1, 1, 0, NOP,          32'h18);
    // Flush in REQ without grant
    add(1, 32'h0000001C, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, NOP,          32'h18);
    add(0, 32'h0,        1, 0, 0, 0, 0, 32'h0,            0, 0, 0, 1, 1, NOP,          32'h1C);
    // Flush in WAIT, late response 3 cycles later is discarded
    add(1, 32'h00000030, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, NOP,          32'h1C);
    add(0, 32'h0,        0, 0, 1, 0, 0, 32'h0,            0, 0, 0, 1, 1, NOP,          32'h30);
    add(0, 32'h0,        1, 0, 0, 0, 0, 32'h0,            0, 0, 0, 1, 0, NOP,          32'h30);
    add(0, 32'h0,        0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 1, 0, NOP,          32'h30);
    add(0, 32'h0,        0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 1, 0, NOP,          32'h30);
    add(1, 32'h00000020, 0, 0, 0, 1, 0, 32'hDEADBEEF,     0, 0, 0, 1, 0, NOP,          32'h30);
    // New fetch from 0x20 returns its own data
    add(1, 32'h00000020, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, NOP,          32'h30);
    add(0, 32'h0,        0, 0, 1, 0, 0, 32'h0,            0, 0, 0, 1, 1, NOP,          32'h20);
    add(0, 32'h0,        0, 0, 0, 1, 0, 32'h00A00113,     0, 0, 0, 1, 0, NOP,          32'h20);
    // Stall 5 cycles in VALID, then back-to-back to 0x14
    for (int k = 0; k < 5; k++)
      add(0, 32'h0,      0, 0, 0, 0, 0, 32'h0,            1, 0, 0, 1, 0, 32'h00A00113, 32'h20);
    add(1, 32'h00000014, 0, 1, 0, 0, 0, 32'h0,            1, 0, 0, 1, 0, 32'h00A00113, 32'h20);
    add(0, 32'h0,        0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 1, 1, 32'h00A00113, 32'h14);
    add(0, 32'h0,        0, 0, 1, 0, 0, 32'h0,            0, 0, 0, 1, 1, 32'h00A00113, 32'h14);
    add(0, 32'h0,        0, 0, 0, 1, 0, 32'h11111111,     0, 0, 0, 1, 0, 32'h00A00113, 32'h14);
    // Back-to-back into a misaligned address, then flush in VALID without ack
    add(1, 32'h00000022, 0, 1, 0, 0, 0, 32'h0,            1, 0, 0, 1, 0, 32'h11111111, 32'h14);
    add(0, 32'h0,        1, 0, 0, 0, 0, 32'h0,            1, 1, 0, 1, 0, NOP,          32'h14);
    // Flush in REQ with grant: drain the outstanding response
    add(1, 32'h00000028, 0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, NOP,          32'h14);
    add(0, 32'h0,        1, 0, 1, 0, 0, 32'h0,            0, 0, 0, 1, 1, NOP,          32'h28);
    add(0, 32'h0,        0, 0, 0, 1, 0, 32'h55555555,     0, 0, 0, 1, 0, NOP,          32'h28);
    add(0, 32'h0,        0, 0, 0, 0, 0, 32'h0,            0, 0, 0, 0, 0, NOP,          32'h28);

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].pv, vecs[i].pc, vecs[i].fl, 1'b0, vecs[i].ack,
           vecs[i].gnt, vecs[i].rv, vecs[i].err, vecs[i].rd);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_mis,
                    vecs[i].e_bus, vecs[i].e_busy, vecs[i].e_req,
                    vecs[i].e_instr, vecs[i].e_addr);
    end

    // Timeout: grant, then no response. Fault appears 255 cycles into WAIT.
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("timeout.imem_req", {31'd0, imem_req}, 32'd1);
    idle_cycle();
    n = 0;
    while (!instr_valid && n < 400) begin
      n++;
      idle_cycle();
    end
    check("timeout.cycles_in_wait", n, 32'd255);
    check("timeout.bus_fault", {31'd0, bus_fault}, 32'd1);
    check("timeout.misalign_fault", {31'd0, misalign_fault}, 32'd0);
    check("timeout.instr_out", instr_out, NOP);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_cycle();
    check_outputs("timeout_done", 0, 0, 0, 0, 0, NOP, 32'h40);

    // Reset asserted in WAIT; a late response afterwards is ignored.
    step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_outputs("wait_before_reset", 0, 0, 0, 1, 0, NOP, 32'h44);
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hBADBAD00);
    check_outputs("reset_in_wait", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle_cycle();
    check_outputs("late_rvalid_ignored", 0, 0, 0, 0, 0, 32'h0, 32'h0);

`ifdef IFETCH_REUSE_EN
    // First fetch of 0x40 goes over the bus and fills the buffer.
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE0013);
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_outputs("reuse_fill", 1, 0, 0, 1, 0, 32'hCAFE0013, 32'h40);
    // Second fetch hits: VALID next cycle, no request.
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_outputs("reuse_hit", 1, 0, 0, 1, 0, 32'hCAFE0013, 32'h40);
    // fence_i invalidates; the next fetch of 0x40 uses the bus.
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_outputs("reuse_after_fence", 0, 0, 0, 1, 1, 32'hCAFE0013, 32'h40);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch unit that sits between the program-counter generator and the instruction memory bus. It accepts a fetch address from the core, checks alignment, and issues a single read over a request/grant/response bus. It buffers the returned instruction and presents it to decode with a valid/ack handshake. It also handles redirect flushes, bus errors and bus timeouts.

Parameters:
ADDR_W, 32, width of fetch address and imem_addr
DATA_W, 32, instruction width
TIMEOUT_CYCLES, 256, max cycles in WAIT before bus timeout fault; counter width is $clog2(TIMEOUT_CYCLES)
NOP_INSTR, 32'h00000013, instruction word driven on any fault (addi x0,x0,0)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active-low
pc_in  input  ADDR_W  fetch address from PC generator
pc_valid  input  1  fetch request for pc_in
flush  input  1  redirect; abandon current fetch
fence_i  input  1  invalidate reuse buffer (ignored without IFETCH_REUSE_EN)
instr_out  output  DATA_W  fetched instruction
instr_valid  output  1  instr_out/fault flags valid
instr_ack  input  1  decode consumed instruction
misalign_fault  output  1  pc_in[1:0] != 0, qualified by instr_valid
bus_fault  output  1  imem_err or timeout, qualified by instr_valid
fetch_busy  output  1  state != IDLE
imem_req  output  1  bus read request
imem_addr  output  ADDR_W  bus read address
imem_gnt  input  1  request accepted
imem_rvalid  input  1  response data valid
imem_rdata  input  DATA_W  response data
imem_err  input  1  response error, qualified by imem_rvalid

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; instr_out=0, instr_valid=0, both faults=0, imem_req=0, imem_addr=0, timeout counter=0. Applies mid-transaction; any later rvalid from the abandoned read is ignored because state is IDLE.
- FSM states: IDLE, REQ, WAIT, VALID, DRAIN.
- IDLE, pc_valid=1, flush=0:
  - If pc_in[1:0]!=0: go to VALID with instr_out=NOP_INSTR, misalign_fault=1. No bus access.
  - Otherwise latch pc_in into imem_addr and go to REQ.
- REQ: imem_req=1, imem_addr held stable until grant.
  - imem_gnt=1: go to WAIT and clear the counter.
  - flush=1 with imem_gnt=0: go to IDLE.
  - flush=1 with imem_gnt=1: go to DRAIN.
- WAIT: imem_req=0; counter increments each cycle.
  - imem_rvalid=1: instr_out=imem_rdata, bus_fault=imem_err (instr_out=NOP_INSTR if err); go to VALID.
  - Counter reaches TIMEOUT_CYCLES-1 without rvalid: bus_fault=1, instr_out=NOP_INSTR; go to VALID.
  - flush=1 without rvalid: go to DRAIN. The counter keeps running.
- VALID: instr_valid=1; instr_out and faults held until instr_ack.
  - instr_ack=1 and pc_valid=1 (aligned): back-to-back, go directly to REQ with the new address.
  - instr_ack=1 and pc_valid=1 (misaligned): stay in VALID with the new fault.
  - instr_ack=1 and pc_valid=0: go to IDLE.
  - flush=1: go to IDLE and drop instr_valid next cycle, regardless of ack.
- DRAIN: discard the outstanding response; go to IDLE on imem_rvalid or on timeout. No output update.
- Priority in every state: rst_n > flush > pc_valid. pc_valid is ignored in REQ, WAIT and DRAIN.
- Latency: pc_valid at cycle 0 → imem_req at cycle 1. With gnt at cycle 1 and rvalid at cycle 2, instr_valid is high at cycle 3.
- At most one outstanding bus transaction. imem_req is never asserted in WAIT, DRAIN or VALID.
- Faults are cleared when leaving VALID.

Optional Feature:
IFETCH_REUSE_EN:
- Adds a one-entry reuse buffer: tag (ADDR_W), data (DATA_W) and a valid bit.
- Filled on every WAIT→VALID transition with imem_err=0 and no timeout.
- In IDLE, or on back-to-back from VALID, an aligned pc_valid with pc_in==tag and buffer valid goes straight to VALID next cycle with the buffered data, with no imem_req.
- Buffer valid is cleared by reset and by fence_i. If fence_i and a fill occur in the same cycle, fence_i wins.
- flush does not invalidate the buffer.
- Without the macro: no buffer, every aligned fetch uses the bus, and fence_i is unused.

Test Plan:
- Basic fetch: pc_valid, pc_in=0x00000010; gnt at cycle 1, rvalid at cycle 2, rdata=0x00500093 → imem_addr=0x10 while req; instr_valid at cycle 3 with instr_out=0x00500093, no faults; after ack, state IDLE and fetch_busy=0.
- Misaligned: pc_in=0x00000006 → no imem_req; next cycle instr_valid=1, misalign_fault=1, instr_out=0x00000013.
- Bus error and timeout: rvalid with err=1 → bus_fault=1, instr_out=NOP. Separately, gnt with no rvalid for 255 cycles → bus_fault=1 exactly TIMEOUT_CYCLES-1 cycles after entering WAIT.
- Flush races:
  - flush in REQ with gnt=0 → IDLE next cycle, imem_req=0.
  - flush in WAIT, then rvalid 3 cycles later with rdata=0xDEADBEEF → instr_valid never asserts; a new fetch from 0x20 returns its own data.
- Back-to-back and stall: in VALID, hold ack=0 for 5 cycles → instr_out stable; then ack=1 with pc_valid, pc_in=0x14 → imem_req the next cycle. Reset asserted in WAIT → all outputs 0 next cycle.
- Reuse (IFETCH_REUSE_EN): fetch 0x40 twice → second fetch has no imem_req, instr_valid after 1 cycle, same data; fence_i then fetch 0x40 → bus request issued.
